keysched_iter: RTL
==================

// Module: keysched_iter
// PURPOSE
//  Iterative AES round-key scheduler: one-cycle-per-round-key stream with valid/ready handshake.
//  DIR=0 (forward): loaded cipher key -> round keys 0..NR. DIR=1 (inverse): loaded last round key
//  -> round keys NR..0, for the decrypt datapath. Sits between key load and the round pipeline.
//  Byte layout: key[15-4r-c] = state[row r][col c], i.e. AES byte b[4c+r].
// PARAMETERS
//  NR        10  rounds; legal 1..10; NR+1 keys emitted per run
//  RIDX_W    4   width of round index outputs
// PORTS
//  clk       in   1        clock
//  reset     in   1        synchronous, active-high reset
//  start     in   1        start request; accepted only when busy=0
//  dir       in   1        0 forward, 1 inverse; sampled with start
//  key_in    in   [15:0][7:0]  cipher key (dir=0) or round-NR key (dir=1); sampled with start
//  busy      out  1        run in progress
//  rk_valid  out  1        rk_out/rk_round valid
//  rk_ready  in   1        consumer accepts current key
//  rk_out    out  [15:0][7:0]  current round key
//  rk_round  out  RIDX_W   round number of rk_out (0..NR)
//  done      out  1        one-cycle pulse on acceptance of final key
// BEHAVIOUR
//  - Reset: busy=0, rk_valid=0, rk_out=0, rk_round=0, done=0; FSM->IDLE. Reset mid-run aborts.
//  - FSM IDLE: start=1 -> latch key_in/dir, rk_out<=key_in, rk_round<=(dir?NR:0), rk_valid<=1, ->RUN.
//    Latency start->first rk_valid: 1 cycle.
//  - RUN: rk_valid=1 held; rk_out/rk_round stable while rk_ready=0 (no change under backpressure).
//    On rk_valid&rk_ready: if final key (round NR fwd / round 0 inv) -> rk_valid<=0, busy<=0,
//    done<=1 next cycle, ->IDLE; else register next key, rk_round +/-1. Throughput 1 key/cycle.
//  - start while busy=1: ignored, no effect on run. start in the same cycle done pulses: ignored
//    (busy still 1 that cycle); accepted from the next cycle.
//  - Columns c0..c3, column c = rows key[15-c],key[11-c],key[7-c],key[3-c]. T(w)=SubWord(RotWord(w))
//    using the forward S-box (RotWord: rows 1,2,3,0). Rcon applied to row 0 only.
//  - Forward i->i+1: n0=c0^T(c3)^rcon[i]; n1=c1^n0; n2=c2^n1; n3=c3^n2.
//  - Inverse i->i-1: p3=c3^c2; p2=c2^c1; p1=c1^c0; p0=c0^T(p3)^rcon[i-1].
//  - rcon[0..9] = 01,02,04,08,10,20,40,80,1b,36. Index always within 0..NR-1; next-key logic purely
//    combinational from registered rk_out, one S-box column instance shared by both directions.
//  - dir/key_in changes during RUN ignored (latched copies used).
//  - busy=1 from cycle after start acceptance through the cycle done pulses (inclusive).
// CONFIGURATION
//  KEYSCHED_CACHE_EN defined: adds ports rd_round in RIDX_W, rd_key out [15:0][7:0], cache_ok out 1.
//   Every accepted key is written into an (NR+1)-entry array at index rk_round; cache_ok=1 after a
//   complete run, cleared by reset or new start. rd_key = entry[rd_round] registered, 1-cycle latency;
//   rd_round>NR -> rd_key=0. Reset clears cache_ok only (array contents don't-care).
//  Not defined: ports absent, no storage; stream-only behaviour identical.
// TESTING
//  1 fwd: key 2b7e1516 28aed2a6 abf71588 09cf4f3c (AES order), rk_ready=1 -> round1
//    a0fafe17 88542cb1 23a33939 2a6c7605, round10 d014f9a8 c9ee2589 e13f0cc8 b6630ca6;
//    11 consecutive valid cycles, done 1 cycle after round10 accept.
//  2 inv: key_in = d014f9a8... (round10), dir=1 -> rk_round 10..0, final key 2b7e1516...; all 11 match test 1.
//  3 backpressure: rk_ready random 30% -> rk_out/rk_round stable while stalled; sequence identical to test 1.
//  4 start pulsed during RUN with different key/dir -> ignored; output sequence unchanged.
//  5 reset asserted at rk_round=5 -> next cycle all outputs 0, IDLE; new start runs clean from round 0.
//  6 CACHE_EN: after test 1, rd_round=10 -> rd_key=d014f9a8... next cycle, cache_ok=1; rd_round=12 -> 0.

Source files
------------

// File: rtl/keysched_iter_if.sv
// Round-key stream bundle: start/dir/key_in request side, rk_* valid/ready stream and status.
interface keysched_iter_if #(
  parameter int unsigned RIDX_W = 4
);
  logic                    start;
  logic                    dir;
  logic [15:0][7:0]        key_in;
  logic                    busy;
  logic                    rk_valid;
  logic                    rk_ready;
  logic [15:0][7:0]        rk_out;
  logic [RIDX_W-1:0]       rk_round;
  logic                    done;

  modport master (
    output start, dir, key_in, rk_ready,
    input  busy, rk_valid, rk_out, rk_round, done
  );

  modport slave (
    input  start, dir, key_in, rk_ready,
    output busy, rk_valid, rk_out, rk_round, done
  );
endinterface

// File: rtl/keysched_iter.sv
// Iterative AES-128 round-key scheduler, forward or inverse, one key per accepted beat.
// Optional KEYSCHED_CACHE_EN adds a readable (NR+1)-entry copy of the last run's keys.
module keysched_iter #(
  parameter int unsigned NR     = 10,
  parameter int unsigned RIDX_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  keysched_iter_if.slave    ks
`ifdef KEYSCHED_CACHE_EN
  ,
  input  logic [RIDX_W-1:0] rd_round,
  output logic [15:0][7:0]  rd_key,
  output logic              cache_ok
`endif
);

  localparam logic [RIDX_W-1:0] NrIdx = RIDX_W'(NR);

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    unique case (idx)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h01;
    endcase
  endfunction

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic              dir_q;
  logic [15:0][7:0]  rk_q;
  logic [RIDX_W-1:0] round_q;
  logic              busy_q, valid_q, done_q;

  logic [3:0][31:0]  col, nxt_col;
  logic [31:0]       t_in, t_out, p3, p2, p1, n0, n1, n2, n3;
  logic [3:0]        rcon_idx;
  logic [15:0][7:0]  rk_next;
  logic              last;

  assign last = dir_q ? (round_q == '0) : (round_q == NrIdx);

  always_comb begin
    for (int c = 0; c < 4; c++) col[c] = {rk_q[15-c], rk_q[11-c], rk_q[7-c], rk_q[3-c]};
  end

  // Index clamped so the idle final-key state never addresses past rcon[NR-1].
  always_comb begin
    rcon_idx = 4'd0;
    if (dir_q) begin
      if (round_q != '0) rcon_idx = 4'(round_q - 1'b1);
    end else if (round_q >= NrIdx) begin
      rcon_idx = 4'(NR - 1);
    end else begin
      rcon_idx = 4'(round_q);
    end
  end

  // Single SubWord(RotWord()) column, fed by c3 forward or the recovered p3 inverse.
  always_comb begin
    p3      = col[3] ^ col[2];
    p2      = col[2] ^ col[1];
    p1      = col[1] ^ col[0];
    t_in    = dir_q ? p3 : col[3];
    t_out   = {sbox(t_in[23:16]), sbox(t_in[15:8]), sbox(t_in[7:0]), sbox(t_in[31:24])}
            ^ {rcon(rcon_idx), 24'h0};
    n0      = col[0] ^ t_out;
    n1      = col[1] ^ n0;
    n2      = col[2] ^ n1;
    n3      = col[3] ^ n2;
    nxt_col = dir_q ? {p3, p2, p1, n0} : {n3, n2, n1, n0};
    rk_next = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) rk_next[15-4*r-c] = nxt_col[c][31-8*r -: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      dir_q   <= 1'b0;
      rk_q    <= '0;
      round_q <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ks.start) begin
            dir_q   <= ks.dir;
            rk_q    <= ks.key_in;
            round_q <= ks.dir ? NrIdx : '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (ks.rk_ready) begin
            if (last) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              rk_q    <= rk_next;
              round_q <= dir_q ? round_q - 1'b1 : round_q + 1'b1;
            end
          end
        end
        // busy stays high through the done pulse so a coincident start is ignored.
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ks.busy     = busy_q;
  assign ks.rk_valid = valid_q;
  assign ks.rk_out   = rk_q;
  assign ks.rk_round = round_q;
  assign ks.done     = done_q;

`ifdef KEYSCHED_CACHE_EN
  logic [15:0][7:0] cache_q [NR+1];
  logic [15:0][7:0] rd_key_q;
  logic             cache_ok_q;

  always_ff @(posedge clk) begin
    if (state_q == StRun && ks.rk_ready) cache_q[round_q] <= rk_q;
    rd_key_q <= (rd_round <= NrIdx) ? cache_q[rd_round] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cache_ok_q <= 1'b0;
    end else if (state_q == StIdle && ks.start) begin
      cache_ok_q <= 1'b0;
    end else if (state_q == StRun && ks.rk_ready && last) begin
      cache_ok_q <= 1'b1;
    end
  end

  assign rd_key   = rd_key_q;
  assign cache_ok = cache_ok_q;
`endif

endmodule
